// File: rtl/wasm_mem_bulk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wasm_mem_bulk_ctrl_pkg
//  Purpose  : Shared types for the WASM bulk-memory sequencer: linear-memory
//             bus request/response, memory op codes, trap codes, bulk command
//             and sequencer state encodings, plus bus request builders.
//  Ports    : n/a (package)
//  Revision : 1.0 - initial release
// ============================================================================
package wasm_mem_bulk_ctrl_pkg;

  localparam int unsigned PAGE_SIZE = 65536;

  typedef enum logic [1:0] {
    MEM_SIZE_1 = 2'd0,
    MEM_SIZE_2 = 2'd1,
    MEM_SIZE_4 = 2'd2,
    MEM_SIZE_8 = 2'd3
  } mem_size_t;

  typedef enum logic [3:0] {
    MEM_OP_NONE    = 4'd0,
    MEM_LOAD_I8_U  = 4'd1,
    MEM_LOAD_I8_S  = 4'd2,
    MEM_LOAD_I32   = 4'd3,
    MEM_LOAD_I64   = 4'd4,
    MEM_STORE_I8   = 4'd5,
    MEM_STORE_I32  = 4'd6,
    MEM_STORE_I64  = 4'd7
  } mem_op_t;

  typedef enum logic [2:0] {
    TRAP_NONE          = 3'd0,
    TRAP_UNREACHABLE   = 3'd1,
    TRAP_OUT_OF_BOUNDS = 3'd2,
    TRAP_DIV_ZERO      = 3'd3,
    TRAP_INT_OVERFLOW  = 3'd4
  } trap_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    mem_size_t   size;
    logic [31:0] addr;
    logic [63:0] wdata;
  } mem_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] rdata;
    logic        rvalid;
    logic        error;
  } mem_bus_resp_t;

  typedef enum logic {
    BULK_FILL = 1'b0,
    BULK_COPY = 1'b1
  } bulk_op_t;

  typedef enum logic [2:0] {
    BULK_IDLE   = 3'd0,
    BULK_CHECK  = 3'd1,
    BULK_READ   = 3'd2,
    BULK_WRITE  = 3'd3,
    BULK_FINISH = 3'd4
  } bulk_state_t;

  localparam mem_bus_req_t MEM_REQ_IDLE = '0;

  // Widening add: the carry lands in bit 32 so an address wrap is visible.
  function automatic logic [32:0] add33(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic mem_bus_req_t mem_rd_req(input logic [31:0] addr);
    mem_bus_req_t r;
    r       = MEM_REQ_IDLE;
    r.valid = 1'b1;
    r.size  = MEM_SIZE_1;
    r.addr  = addr;
    return r;
  endfunction

  function automatic mem_bus_req_t mem_wr_req(input logic [31:0] addr, input logic [7:0] data);
    mem_bus_req_t r;
    r       = MEM_REQ_IDLE;
    r.valid = 1'b1;
    r.write = 1'b1;
    r.size  = MEM_SIZE_1;
    r.addr  = addr;
    r.wdata = {56'd0, data};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wasm_mem_bulk_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : wasm_mem_bulk_ctrl_if
//  Purpose  : Linear-memory bus between the bulk sequencer and wasm_memory.
//  Signals  : req  - byte request (valid/write/size/addr/wdata)
//             op   - memory op code accompanying the request
//             resp - ready/rdata/rvalid/error from memory
//  Modports : master (sequencer side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface wasm_mem_bulk_ctrl_if;
  import wasm_mem_bulk_ctrl_pkg::*;

  mem_bus_req_t  req;
  mem_op_t       op;
  mem_bus_resp_t resp;

  modport master (output req, output op, input resp);
  modport slave  (input req, input op, output resp);

endinterface
`default_nettype wire

// File: rtl/wasm_mem_bulk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wasm_mem_bulk_ctrl
//  Purpose  : Sequencer for WASM memory.fill / memory.copy. Accepts one
//             command, performs the up-front bounds check once, then moves
//             one byte per bus access until done or trapped.
//  Ports    : clk, rst_n         - clock, async active-low reset
//             cmd_*_i / cmd_ready_o - command handshake and operands
//             cur_pages_i        - current memory size in pages
//             mem_if (master)    - linear-memory bus request/op/response
//             busy_o, done_o, trap_o - status; trap_o valid with done_o
//  Revision : 1.0 - initial release
// ============================================================================
module wasm_mem_bulk_ctrl
  import wasm_mem_bulk_ctrl_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = PAGE_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  bulk_op_t                     cmd_op_i,
  input  logic [31:0]                  cmd_dst_i,
  input  logic [31:0]                  cmd_src_i,
  input  logic [31:0]                  cmd_len_i,
  input  logic [7:0]                   cmd_val_i,
  input  logic [31:0]                  cur_pages_i,
  wasm_mem_bulk_ctrl_if.master         mem_if,
  output logic                         busy_o,
  output logic                         done_o,
  output trap_t                        trap_o
);

  bulk_state_t state_q;
  bulk_op_t    op_q;
  logic [31:0] dst_q;
  logic [31:0] src_q;
  logic [31:0] rem_q;     // bytes still to write; holds len during CHECK
  logic [31:0] off_q;
  logic [7:0]  val_q;
  logic [7:0]  byte_q;
  logic        back_q;
  logic        busy_q;
  logic        ready_q;
  logic        done_q;
  trap_t       trap_q;

  logic [63:0] lim_d;
  logic [32:0] dst_end_d;
  logic [32:0] src_end_d;
  logic        oob_d;
  logic        back_d;
  logic [31:0] start_off_d;
  logic [31:0] off_d;
  logic [31:0] rem_d;
  logic        fin_d;
  trap_t       fin_trap_d;

  logic        unused_rdata;
  assign unused_rdata = ^mem_if.resp.rdata[63:8];

  // Bounds check and finish decision. The limit is formed wide so that a
  // 65536-page memory (exactly 4 GiB) does not wrap to zero.
  always_comb begin
    lim_d       = 64'(cur_pages_i) * 64'(PAGE_BYTES);
    dst_end_d   = add33(dst_q, rem_q);
    src_end_d   = add33(src_q, rem_q);
    oob_d       = (64'(dst_end_d) > lim_d) ||
                  ((op_q == BULK_COPY) && (64'(src_end_d) > lim_d));
    // Overlapping copy with dst above src must run top-down (memmove).
    back_d      = (op_q == BULK_COPY) && (dst_q > src_q);
    start_off_d = back_d ? (rem_q - 32'd1) : 32'd0;
    off_d       = back_q ? (off_q - 32'd1) : (off_q + 32'd1);
    rem_d       = rem_q - 32'd1;

    fin_d      = 1'b0;
    fin_trap_d = TRAP_NONE;
    case (state_q)
      BULK_CHECK: begin
        fin_d      = oob_d || (rem_q == 32'd0);
        fin_trap_d = oob_d ? TRAP_OUT_OF_BOUNDS : TRAP_NONE;
      end
      BULK_READ: begin
        if (mem_if.resp.ready && mem_if.resp.error) begin
          fin_d      = 1'b1;
          fin_trap_d = TRAP_OUT_OF_BOUNDS;
        end
      end
      BULK_WRITE: begin
        if (mem_if.resp.ready) begin
          fin_d      = mem_if.resp.error || (rem_q == 32'd1);
          fin_trap_d = mem_if.resp.error ? TRAP_OUT_OF_BOUNDS : TRAP_NONE;
        end
      end
      default: ;
    endcase
  end

  // Bus request is a pure decode of registered state, so it stays stable
  // across ready=0 stalls without any extra holding logic.
  always_comb begin
    mem_if.req = MEM_REQ_IDLE;
    mem_if.op  = MEM_OP_NONE;
    case (state_q)
      BULK_READ: begin
        mem_if.req = mem_rd_req(src_q + off_q);
        mem_if.op  = MEM_LOAD_I8_U;
      end
      BULK_WRITE: begin
        mem_if.req = mem_wr_req(dst_q + off_q, (op_q == BULK_FILL) ? val_q : byte_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BULK_IDLE;
      op_q    <= BULK_FILL;
      dst_q   <= '0;
      src_q   <= '0;
      rem_q   <= '0;
      off_q   <= '0;
      val_q   <= '0;
      byte_q  <= '0;
      back_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      trap_q  <= TRAP_NONE;
    end else begin
      done_q <= 1'b0;
      trap_q <= TRAP_NONE;
      case (state_q)
        BULK_IDLE: begin
          if (cmd_valid_i && ready_q) begin
            op_q    <= cmd_op_i;
            dst_q   <= cmd_dst_i;
            src_q   <= cmd_src_i;
            rem_q   <= cmd_len_i;
            val_q   <= cmd_val_i;
            state_q <= BULK_CHECK;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        BULK_CHECK: begin
          back_q  <= back_d;
          off_q   <= start_off_d;
          state_q <= (op_q == BULK_FILL) ? BULK_WRITE : BULK_READ;
        end
        BULK_READ: begin
          if (mem_if.resp.ready && mem_if.resp.rvalid) begin
            byte_q  <= mem_if.resp.rdata[7:0];
            state_q <= BULK_WRITE;
          end
        end
        BULK_WRITE: begin
          if (mem_if.resp.ready) begin
            rem_q <= rem_d;
            off_q <= off_d;
            if (op_q == BULK_COPY) begin
              state_q <= BULK_READ;
            end
          end
        end
        BULK_FINISH: begin
          state_q <= BULK_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= BULK_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
      // Completion and traps override the normal next state.
      if (fin_d) begin
        state_q <= BULK_FINISH;
        done_q  <= 1'b1;
        trap_q  <= fin_trap_d;
      end
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign trap_o      = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_wasm_mem_bulk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wasm_mem_bulk_ctrl
//  Purpose  : Self-checking bench for wasm_mem_bulk_ctrl. A byte-array memory
//             answers the bus; a memmove/memset reference model predicts
//             traps, write order, latency and final memory contents.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wasm_mem_bulk_ctrl;
  import wasm_mem_bulk_ctrl_pkg::*;

  localparam int MEM_BYTES = 131072;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  bulk_op_t    cmd_op = BULK_FILL;
  logic [31:0] cmd_dst = '0;
  logic [31:0] cmd_src = '0;
  logic [31:0] cmd_len = '0;
  logic [7:0]  cmd_val = '0;
  logic [31:0] cur_pages = 32'd1;
  logic        busy;
  logic        done;
  trap_t       trap;

  wasm_mem_bulk_ctrl_if bus_if ();

  wasm_mem_bulk_ctrl #(.PAGE_BYTES(PAGE_SIZE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_dst_i   (cmd_dst),
    .cmd_src_i   (cmd_src),
    .cmd_len_i   (cmd_len),
    .cmd_val_i   (cmd_val),
    .cur_pages_i (cur_pages),
    .mem_if      (bus_if.master),
    .busy_o      (busy),
    .done_o      (done),
    .trap_o      (trap)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // ---------------- memory model on the bus ----------------
  logic [7:0]  bus_mem [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        bus_ready = 1'b1;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          req_cnt = 0;
  int          err_target = -1;
  logic [31:0] wq [$];
  logic [1:0]  stall_mode = 2'd0;

  always_comb begin
    bus_if.resp        = '0;
    bus_if.resp.ready  = bus_ready;
    bus_if.resp.rvalid = bus_ready && bus_if.req.valid && !bus_if.req.write;
    bus_if.resp.rdata  = {56'd0, bus_mem[bus_if.req.addr[16:0]]};
    bus_if.resp.error  = bus_ready && bus_if.req.valid && bus_if.req.write && (wr_cnt == err_target);
  end

  always @(posedge clk) begin
    if (rst_n && bus_if.req.valid) begin
      req_cnt <= req_cnt + 1;
      if (bus_ready) begin
        if (bus_if.req.write) begin
          wq.push_back(bus_if.req.addr);
          wr_cnt <= wr_cnt + 1;
          if (!bus_if.resp.error) bus_mem[bus_if.req.addr[16:0]] = bus_if.req.wdata[7:0];
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
    end
  end

  // Bus protocol monitor and ready generator.
  int           bcyc = 0;
  logic         prev_stall = 1'b0;
  mem_bus_req_t prev_req = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_ready  = 1'b1;
      prev_stall = 1'b0;
      bcyc       = 0;
    end else begin
      if (bus_if.req.valid) begin
        chk("valid_busy", busy, 1'b1);
        chk("mem_op", bus_if.op, bus_if.req.write ? MEM_OP_NONE : MEM_LOAD_I8_U);
        chk("size", bus_if.req.size, MEM_SIZE_1);
      end
      if (prev_stall) chk("hold", bus_if.req, prev_req);
      prev_req = bus_if.req;
      bcyc = busy ? bcyc + 1 : 0;
      case (stall_mode)
        2'd0:    bus_ready = 1'b1;
        2'd1:    bus_ready = ($urandom % 4) != 0;
        default: bus_ready = !(bcyc >= 3 && bcyc <= 5);
      endcase
      prev_stall = bus_if.req.valid && !bus_ready;
    end
  end

  // ---------------- command runner with reference model ----------------
  task automatic run_cmd(input string tag, input bulk_op_t op, input logic [31:0] dst,
                         input logic [31:0] src, input logic [31:0] len, input logic [7:0] val,
                         input logic [31:0] pages, input int err_at, input logic [1:0] smode);
    logic [63:0] lim;
    logic [31:0] o;
    logic [31:0] a;
    bit          oob, back, trap_exp, err_hit;
    logic [31:0] ea [$];
    logic [7:0]  ed [$];
    int          nexp, nhs, wbase, rbase, qbase, wqbase, cyc, lat, budget, nrd;

    lim  = 64'(pages) * 64'(PAGE_SIZE);
    oob  = (64'(dst) + 64'(len) > lim) || (op == BULK_COPY && (64'(src) + 64'(len) > lim));
    back = (op == BULK_COPY) && (dst > src);
    if (!oob) begin
      // Snapshot source bytes before anything is written: memmove semantics.
      for (int i = 0; i < int'(len); i++) begin
        o = back ? (len - 32'd1 - 32'(i)) : 32'(i);
        a = src + o;
        ea.push_back(dst + o);
        ed.push_back(op == BULK_FILL ? val : ref_mem[a[16:0]]);
      end
    end
    nexp     = ea.size();
    trap_exp = oob;
    err_hit  = !oob && err_at >= 0 && err_at < nexp;
    nhs      = nexp;
    if (err_hit) begin
      nexp     = err_at;
      nhs      = err_at + 1;
      trap_exp = 1'b1;
    end
    nrd = (op == BULK_COPY) ? nhs : 0;

    wbase  = wr_cnt;
    rbase  = rd_cnt;
    qbase  = req_cnt;
    wqbase = wq.size();
    err_target = (err_at >= 0) ? wbase + err_at : -1;
    stall_mode = smode;
    cur_pages  = pages;
    budget     = 100 + 8 * int'(len);

    chk({tag, "_ready"}, cmd_ready, 1'b1);
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_len = len; cmd_val = val;
    cmd_valid = 1'b1;
    @(negedge clk);
    // Garbage command held valid while busy must be ignored.
    cmd_op  = bulk_op_t'(1'($urandom));
    cmd_dst = $urandom; cmd_src = $urandom; cmd_len = $urandom; cmd_val = 8'($urandom);
    cyc = 1;
    chk({tag, "_busy"}, busy, 1'b1);
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_trap"}, trap, trap_exp ? TRAP_OUT_OF_BOUNDS : TRAP_NONE);
    if (smode == 2'd0 && !err_hit) begin
      if (oob || len == 0) lat = 2;
      else lat = (op == BULK_FILL) ? 2 + int'(len) : 2 + 2 * int'(len);
      chk({tag, "_latency"}, cyc, lat);
    end
    chk({tag, "_nwr"}, wr_cnt - wbase, nhs);
    chk({tag, "_nrd"}, rd_cnt - rbase, nrd);
    if (oob) chk({tag, "_noreq"}, req_cnt - qbase, 0);
    for (int i = 0; i < nhs && (wqbase + i) < wq.size(); i++)
      chk($sformatf("%s_waddr%0d", tag, i), wq[wqbase + i], ea[i]);

    for (int i = 0; i < nexp; i++) begin
      a = ea[i];
      ref_mem[a[16:0]] = ed[i];
    end
    for (int i = 0; i < ea.size(); i++) begin
      a = ea[i];
      chk($sformatf("%s_mem%0h", tag, a), bus_mem[a[16:0]], ref_mem[a[16:0]]);
    end
    a = dst - 32'd1;
    chk({tag, "_below"}, bus_mem[a[16:0]], ref_mem[a[16:0]]);
    a = dst + len;
    chk({tag, "_above"}, bus_mem[a[16:0]], ref_mem[a[16:0]]);

    @(negedge clk);
    chk({tag, "_done_low"}, done, 1'b0);
    chk({tag, "_trap_idle"}, trap, TRAP_NONE);
    chk({tag, "_idle_ready"}, cmd_ready, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    err_target = -1;
    stall_mode = 2'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_trap"}, trap, TRAP_NONE);
    chk({tag, "_valid"}, bus_if.req.valid, 1'b0);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic preset_1234();
    for (int i = 0; i < 4; i++) begin
      bus_mem[16 + i] = 8'(i + 1);
      ref_mem[16 + i] = 8'(i + 1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] pages, lim, dst, src, len;
    bulk_op_t    op;
    int          err_at, n;

    for (int i = 0; i < MEM_BYTES; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd("fill", BULK_FILL, 32'h100, 32'h0, 32'd4, 8'hAB, 32'd1, -1, 2'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("fill_ab%0d", i), bus_mem[17'h100 + i], 8'hAB);

    preset_1234();
    run_cmd("cpy_back", BULK_COPY, 32'h12, 32'h10, 32'd4, 8'h00, 32'd1, -1, 2'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("cpy_back_b%0d", i), bus_mem[17'h12 + i], 8'(i + 1));
    preset_1234();
    run_cmd("cpy_fwd", BULK_COPY, 32'h0E, 32'h10, 32'd4, 8'h00, 32'd1, -1, 2'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("cpy_fwd_b%0d", i), bus_mem[17'h0E + i], 8'(i + 1));

    run_cmd("oob_fill", BULK_FILL, 32'hFFFE, 32'h0, 32'd3, 8'h11, 32'd1, -1, 2'd0);
    run_cmd("edge_len0", BULK_FILL, 32'h10000, 32'h0, 32'd0, 8'h22, 32'd1, -1, 2'd0);
    run_cmd("past_len0", BULK_FILL, 32'h10001, 32'h0, 32'd0, 8'h33, 32'd1, -1, 2'd0);
    run_cmd("carry33", BULK_COPY, 32'h0, 32'hFFFF_FFFF, 32'd2, 8'h00, 32'd1, -1, 2'd0);
    run_cmd("cpy_len0", BULK_COPY, 32'h30, 32'h20, 32'd0, 8'h00, 32'd1, -1, 2'd0);
    run_cmd("stall", BULK_COPY, 32'h800, 32'h400, 32'd6, 8'h00, 32'd1, -1, 2'd2);
    run_cmd("wr_err", BULK_FILL, 32'h200, 32'h0, 32'd4, 8'h5C, 32'd1, 1, 2'd0);
    chk("wr_err_first", bus_mem[17'h200], 8'h5C);

    // Asynchronous reset in the middle of a fill.
    n = wr_cnt;
    cur_pages = 32'd1;
    cmd_op = BULK_FILL; cmd_dst = 32'h300; cmd_len = 32'd8; cmd_val = 8'h5A;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    n = wr_cnt - n;
    chk("rst_partial", (n > 0) && (n < 8), 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_b%0d", i), bus_mem[17'h300 + i], (i < n) ? 8'h5A : ref_mem[17'h300 + i]);
      ref_mem[17'h300 + i] = bus_mem[17'h300 + i];
    end
    @(negedge clk);
    run_cmd("after_rst", BULK_FILL, 32'h340, 32'h0, 32'd3, 8'hC3, 32'd1, -1, 2'd0);

    // Randomized commands.
    for (int k = 0; k < 30; k++) begin
      pages = 32'd1 + ($urandom % 2);
      lim   = pages * PAGE_SIZE;
      len   = $urandom % 13;
      op    = bulk_op_t'(1'($urandom));
      case ($urandom % 3)
        0:       dst = $urandom % lim;
        1:       dst = lim - len - 32'd2 + ($urandom % 5);
        default: dst = 32'h1000 + ($urandom % 64);
      endcase
      if ($urandom % 4 == 0) src = lim - len - 32'd2 + ($urandom % 5);
      else                   src = dst + ($urandom % 9) - 32'd4;
      err_at = ($urandom % 6 == 0) ? int'($urandom % (len + 1)) : -1;
      run_cmd($sformatf("rnd%0d", k), op, dst, src, len, 8'($urandom), pages, err_at,
              2'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
